// File: rtl/input_process_spi.sv
`default_nettype none
// ============================================================================
// Module      : input_process_spi
// Description : Serial (MSB-first) word receiver feeding a show-ahead FIFO
//               with registered backpressure. Define RX_FRAME_CHECK_EN to
//               enable the 16-bit framing check.
// Revision    : 1.0 - initial release
// ============================================================================
module input_process_spi #(
    parameter int DEPTH       = 8,
    parameter int STOP_MARGIN = 2
) (
    input  logic        RX_CLK,
    input  logic        RST,
    input  logic        RX_DATA,
    input  logic        RX_EN,
    input  logic        RX_LOAD,
    output logic        TX_STOP,
    output logic [15:0] DATA,
    output logic        VALID,
    input  logic        RD_REQ,
    output logic        OVF,
    output logic        FRAME_ERR,
    output logic [1:0]  state_mon
);

    localparam int              c_AW         = $clog2(DEPTH);
    localparam int              c_FW         = c_AW + 1;
    localparam logic [c_FW-1:0] c_FULL       = c_FW'(DEPTH);
    localparam logic [c_FW-1:0] c_STOP_LEVEL = c_FW'(DEPTH - STOP_MARGIN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_RESYNC  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    // Only 15 bits are kept: the oldest bit of a word falls off on the
    // completing edge, so a 16th stored bit could never be observed.
    logic [14:0]       r_shift;
    logic [3:0]        r_cnt;
    logic              r_frame_err;
    logic              w_wr_req;
    logic              w_frame_err;
    logic [15:0]       w_word;

    logic [15:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_FW-1:0]   r_fill;
    logic [c_FW-1:0]   w_fill_next;
    logic              r_ovf;
    logic              r_tx_stop;
    logic              w_pop;
    logic              w_push;
    logic              w_full;

    assign w_word = {r_shift, RX_DATA};

    always_ff @(posedge RX_CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_req     = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            ST_IDLE, ST_SHIFT: begin
                if (RX_EN) begin
                    if (RX_LOAD) begin
                        w_state_next = ST_IDLE;
`ifdef RX_FRAME_CHECK_EN
                        if (r_cnt == 4'd15) begin
                            w_wr_req = 1'b1;
                        end else begin
                            w_frame_err = 1'b1;
                        end
`else
                        w_wr_req = 1'b1;
`endif
                    end else begin
                        w_state_next = ST_SHIFT;
`ifdef RX_FRAME_CHECK_EN
                        if (r_cnt == 4'd15) begin
                            w_frame_err  = 1'b1;
                            w_state_next = ST_RESYNC;
                        end
`endif
                    end
                end
            end
            ST_RESYNC: begin
                if (RX_EN && RX_LOAD) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge RX_CLK or posedge RST) begin
        if (RST) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (RX_EN) begin
                r_shift <= {r_shift[13:0], RX_DATA};
                r_cnt   <= RX_LOAD ? 4'd0 : r_cnt + 4'd1;
            end
        end
    end

    // A pop in the same cycle frees the head slot, so a write at full is kept.
    assign w_pop  = RD_REQ && (r_fill != '0);
    assign w_full = (r_fill == c_FULL);
    assign w_push = w_wr_req && (!w_full || w_pop);

    always_comb begin
        w_fill_next = r_fill;
        case ({w_push, w_pop})
            2'b10:   w_fill_next = r_fill + c_FW'(1);
            2'b01:   w_fill_next = r_fill - c_FW'(1);
            default: w_fill_next = r_fill;
        endcase
    end

    always_ff @(posedge RX_CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_ovf     <= 1'b0;
            r_tx_stop <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_wr_req && !w_push) begin
                r_ovf <= 1'b1;
            end
            r_fill    <= w_fill_next;
            r_tx_stop <= (w_fill_next >= c_STOP_LEVEL);
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign VALID     = (r_fill != '0);
    assign DATA      = VALID ? r_mem[r_rd_ptr] : 16'h0000;
    assign TX_STOP   = r_tx_stop;
    assign OVF       = r_ovf;
    assign FRAME_ERR = r_frame_err;
    assign state_mon = r_state;

endmodule
`default_nettype wire

// File: doc/input_process_spi.md
INPUT_PROCESS_SPI -- requirements
Module: input_process_spi

Interface
REQ-001 Parameters SHALL be: DEPTH, default 8, FIFO depth in 16-bit words (power of 2, 4..64); STOP_MARGIN, default 2, free words at or below which TX_STOP asserts (1..DEPTH-1).
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-003 RX_CLK  in  1  sole clock; all logic on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 RX_DATA  in  1  serial bit, MSB first.
REQ-006 RX_EN  in  1  RX_DATA holds a valid bit this cycle.
REQ-007 RX_LOAD  in  1  qualified by RX_EN; marks the last bit of a word.
REQ-008 TX_STOP  out  1  backpressure to the remote transmitter.
REQ-009 DATA  out  16  head-of-FIFO word (show-ahead).
REQ-010 VALID  out  1  FIFO not empty; DATA is meaningful.
REQ-011 RD_REQ  in  1  pops the head word when VALID=1; ignored when VALID=0.
REQ-012 OVF  out  1  sticky: a completed word was dropped because the FIFO was full.
REQ-013 FRAME_ERR  out  1  one-cycle pulse on framing error.
REQ-014 state_mon  out  2  current receiver state encoding.

Function
REQ-015 Receiver FSM states SHALL be: IDLE=0, SHIFT=1, RESYNC=2; encoding 3 SHALL return to IDLE on the next edge.
REQ-016 Each cycle with RX_EN=1 SHALL shift RX_DATA into a 16-bit register LSB end and increment a 4-bit bit counter; a cycle with RX_EN=0 SHALL leave both unchanged.
REQ-017 IDLE->SHIFT SHALL occur on the first RX_EN=1 bit with RX_LOAD=0; SHIFT->IDLE SHALL occur on the bit with RX_EN=1 and RX_LOAD=1.
REQ-018 Word completion SHALL occur on the RX_EN&RX_LOAD cycle; the completed word {shift[14:0],RX_DATA} SHALL be written to the FIFO on that same edge; the bit counter SHALL clear to 0.
REQ-019 Latency: a completed word SHALL appear on DATA with VALID=1 in the cycle after completion when the FIFO was empty.
REQ-020 FIFO full at completion: the word SHALL be dropped, FIFO contents unchanged, and OVF set to 1 until reset.
REQ-021 Pop and write in the same cycle SHALL both take effect, fill level unchanged; this SHALL also apply at full (the pop frees the slot, no OVF) and at empty with VALID=0 (write only).
REQ-022 RD_REQ with VALID=0 SHALL have no effect; pointers SHALL wrap modulo DEPTH.
REQ-023 TX_STOP SHALL be registered and SHALL equal 1 in the cycle after (DEPTH - fill) <= STOP_MARGIN, and 0 otherwise.
REQ-024 A DEPTH-entry fill counter SHALL range 0..DEPTH; VALID = (fill != 0).

Reset
REQ-025 While RST=1: state=IDLE, bit counter=0, shift register=0, FIFO empty, VALID=0, DATA=0, TX_STOP=0, OVF=0, FRAME_ERR=0, state_mon=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after release, reception SHALL restart at the next RX_EN bit as the first bit of a new word.

Configuration
REQ-027 Macro RX_FRAME_CHECK_EN SHALL select the framing check.
REQ-028 With RX_FRAME_CHECK_EN defined: RX_LOAD at a bit count other than 15 SHALL drop the word, pulse FRAME_ERR, and go to IDLE; a 16th bit without RX_LOAD SHALL pulse FRAME_ERR and go to RESYNC; RESYNC SHALL discard bits until RX_EN&RX_LOAD, then go to IDLE without writing.
REQ-029 Without RX_FRAME_CHECK_EN: every RX_EN&RX_LOAD SHALL write the current shift contents regardless of count, RESYNC SHALL be unreachable, and FRAME_ERR SHALL be tied to 0.

Verification
REQ-030 Scenario: send 0xA5C3 (16 bits, RX_LOAD on bit 16), RD_REQ=0 -> next cycle VALID=1, DATA=0xA5C3, state_mon back to 0.
REQ-031 Scenario: DEPTH=8, STOP_MARGIN=2, send 6 words without reading -> TX_STOP=1 one cycle after the 6th completion; pop one word -> TX_STOP=0 next cycle.
REQ-032 Scenario: fill 8 words, send a 9th -> OVF=1, FIFO still holds words 1..8 in order; send a 10th with RD_REQ pulsed on its completion cycle -> word 10 accepted, OVF stays 1.
REQ-033 Scenario (RX_FRAME_CHECK_EN): RX_LOAD on bit 12 -> FRAME_ERR pulse, nothing written; 20 bits without RX_LOAD -> FRAME_ERR at bit 16, state_mon=2 until RX_LOAD, then a clean 0x1234 frame is received correctly.
REQ-034 Scenario: assert RST after bit 7 of a word, release, then send 0xFFFF -> DATA=0xFFFF, VALID=1, no FRAME_ERR, OVF=0.
REQ-035 Scenario: RX_EN toggled 0/1 every cycle during a 0x8001 frame -> DATA=0x8001, bits on RX_EN=0 cycles ignored.
